// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage valid/ready register pipeline carrying a WIDTH-bit word.
// Stalled stages hold, empty stages accept (bubble collapse), synchronous flush
// and reset, registered occupancy count.
// Optional feature macro: REG_PIPE_QBAR_EN adds a registered complement output qbar.
module reg_pipe #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           d,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           q,
`ifdef REG_PIPE_QBAR_EN
    output logic [WIDTH-1:0]           qbar,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] data     [DEPTH];
    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] up_valid;
    logic [WIDTH-1:0] up_data  [DEPTH];
    logic             in_xfer;
    logic             out_xfer;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        // Unrolled ready chain: a stage can load if any stage from here to the
        // output is empty, or the output is being drained.
        assign ready[i] = out_ready || !(&valid[DEPTH-1:i]);

        if (i == 0) begin : g_first
            assign up_valid[i] = in_valid;
            assign up_data[i]  = d;
        end else begin : g_rest
            assign up_valid[i] = valid[i-1];
            assign up_data[i]  = data[i-1];
        end
    end

    assign in_ready  = ready[0] && !flush;
    assign out_valid = valid[DEPTH-1];
    assign q         = data[DEPTH-1];
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    // Stage registers and occupancy count; reset beats flush beats normal flow.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= RESET_VAL;
            end
        end else if (flush) begin
            // Data is deliberately left in place; only the valids are dropped.
            valid <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ready[i]) begin
                    valid[i] <= up_valid[i];
                    // Empty stages keep stale data to avoid needless toggling.
                    if (up_valid[i]) begin
                        data[i] <= up_data[i];
                    end
                end
            end
            count <= count + CW'(in_xfer) - CW'(out_xfer);
        end
    end

`ifdef REG_PIPE_QBAR_EN
    // Complement register written from the same next-state as the last stage,
    // so it always matches ~q in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            qbar <= ~RESET_VAL;
        end else if (!flush && ready[DEPTH-1] && up_valid[DEPTH-1]) begin
            qbar <= ~up_data[DEPTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// Self-checking bench for reg_pipe (WIDTH=8, DEPTH=4). The reference model keeps
// in-flight words in a queue with their stage position; a word advances unless
// every stage ahead of it is occupied and the output is stalled.
// qbar checks are active when REG_PIPE_QBAR_EN is defined.
module tb_reg_pipe;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam logic [7:0]  RV    = 8'h00;

    logic       clk = 1'b0;
    logic       reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] d, q;
    logic [7:0] qbar;
    logic [2:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_pipe #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .RESET_VAL(RV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .d        (d),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .q        (q),
`ifdef REG_PIPE_QBAR_EN
        .qbar     (qbar),
`endif
        .count    (count)
    );

`ifndef REG_PIPE_QBAR_EN
    assign qbar = ~q;
`endif

    // Reference model
    typedef struct {
        logic [7:0] data;
        int         pos;
    } ent_t;

    ent_t       mq[$];
    logic [7:0] q_exp = RV;

    function automatic logic m_out_valid();
        return mq.size() > 0 && mq[0].pos == int'(DEPTH) - 1;
    endfunction

    function automatic logic [2:0] m_count();
        return 3'(mq.size());
    endfunction

    function automatic logic m_in_ready();
        return (mq.size() < int'(DEPTH) || out_ready) && !flush;
    endfunction

    task automatic model_edge();
        ent_t e;
        logic acc;
        if (reset) begin
            mq.delete();
            q_exp = RV;
        end else if (flush) begin
            mq.delete();
        end else begin
            acc = (mq.size() < int'(DEPTH)) || out_ready;
            for (int k = 0; k < mq.size(); k++) begin
                // k words sit ahead; the word moves if there is a free slot ahead
                if (out_ready || k < int'(DEPTH) - 1 - mq[k].pos) begin
                    e = mq[k];
                    e.pos++;
                    mq[k] = e;
                end
            end
            if (mq.size() > 0 && mq[0].pos == int'(DEPTH)) void'(mq.pop_front());
            if (acc && in_valid) begin
                e.data = d;
                e.pos  = 0;
                mq.push_back(e);
            end
            if (m_out_valid()) q_exp = mq[0].data;
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic iv, input logic [7:0] dd,
                         input logic orr);
        reset = r; flush = f; in_valid = iv; d = dd; out_ready = orr;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b1, 8'hA5, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b1, 8'hA5, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++;
        if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q got %h want 00", q); end
        n_checks++;
        if (qbar !== 8'hFF) begin n_fail++; $display("FAIL reset_qbar got %h want ff", qbar); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_streaming();
        int first_edge = -1;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        step();
        for (int e = 0; e < 12; e++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(e + 1), 1'b1);
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready edge %0d got %b want 1", e, in_ready); end
            step();
            if (out_valid === 1'b1 && first_edge < 0) first_edge = e;
            if (e >= int'(DEPTH) - 1) begin
                n_checks++;
                if (q !== 8'(e - int'(DEPTH) + 2) || out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_q edge %0d got %h/%b want %h/1", e, q, out_valid, 8'(e - int'(DEPTH) + 2));
                end
            end
        end
        n_checks++;
        if (first_edge != int'(DEPTH) - 1) begin n_fail++; $display("FAIL stream_latency got %0d want %0d", first_edge, DEPTH - 1); end
        n_checks++;
        if (count !== 3'd4) begin n_fail++; $display("FAIL stream_count got %0d want 4", count); end
    endtask

    task automatic test_back_pressure();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(i), 1'b0);
            step();
        end
        drive(1'b0, 1'b0, 1'b1, 8'h05, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready got %b want 0", in_ready); end
        n_checks++;
        if (count !== 3'd4 || q !== 8'h01) begin n_fail++; $display("FAIL bp_full got count %0d q %h want 4 01", count, q); end
        step();
        n_checks++;
        if (count !== 3'd4 || q !== 8'h01) begin n_fail++; $display("FAIL bp_hold got count %0d q %h want 4 01", count, q); end
        drive(1'b0, 1'b0, 1'b1, 8'h05, 1'b1);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        step();
        n_checks++;
        if (count !== 3'd4 || q !== 8'h02) begin n_fail++; $display("FAIL bp_one_xfer got count %0d q %h want 4 02", count, q); end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        n_checks++;
        if (q !== 8'h02 || count !== m_count()) begin n_fail++; $display("FAIL bp_restall got q %h count %0d want 02 %0d", q, count, m_count()); end
    endtask

    task automatic test_bubble();
        logic [7:0] seq [8] = '{8'h11, 8'h00, 8'h00, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00};
        logic       vld [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, vld[i], seq[i], 1'b0);
            step();
        end
        n_checks++;
        if (count !== 3'd2 || q !== 8'h11 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bubble_settle got count %0d q %h ov %b want 2 11 1", count, q, out_valid);
        end
        // Second word must already be in the stage right behind the output.
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step();
        n_checks++;
        if (count !== 3'd1 || q !== 8'h22 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bubble_stage2 got count %0d q %h ov %b want 1 22 1", count, q, out_valid);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        step();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        n_checks++;
        if (count !== 3'd3 || q !== 8'h41 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL flush_pre got count %0d q %h ov %b want 3 41 1", count, q, out_valid);
        end
        drive(1'b0, 1'b1, 1'b1, 8'h99, 1'b1);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
        step();
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || q !== 8'h41) begin
            n_fail++; $display("FAIL flush_post got count %0d ov %b q %h want 0 0 41", count, out_valid, q);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step();
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_dropped got count %0d ov %b want 0 0", count, out_valid);
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
            step();
            n_checks++;
            if (qbar !== ~q) begin n_fail++; $display("FAIL midrst_qbar got %h want %h", qbar, ~q); end
        end
        n_checks++;
        if (count !== 3'd4) begin n_fail++; $display("FAIL midrst_full got count %0d want 4", count); end
        drive(1'b1, 1'b0, 1'b1, 8'h5A, 1'b1);
        step();
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || q !== RV || qbar !== ~RV) begin
            n_fail++; $display("FAIL midrst_after got count %0d ov %b q %h qbar %h want 0 0 %h %h",
                               count, out_valid, q, qbar, RV, ~RV);
        end
    endtask

    task automatic test_random();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        for (int c = 0; c < 600; c++) begin
            // Alternate between congested and draining phases.
            drive(($urandom_range(63) == 0), ($urandom_range(15) == 0), ($urandom_range(3) != 0),
                  8'($urandom), ((c / 50) % 2 == 0) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0));
            n_checks++;
            if (in_ready !== m_in_ready()) begin n_fail++; $display("FAIL rand_in_ready cyc %0d got %b want %b", c, in_ready, m_in_ready()); end
            step();
            n_checks++;
            if (out_valid !== m_out_valid()) begin n_fail++; $display("FAIL rand_out_valid cyc %0d got %b want %b", c, out_valid, m_out_valid()); end
            n_checks++;
            if (count !== m_count()) begin n_fail++; $display("FAIL rand_count cyc %0d got %0d want %0d", c, count, m_count()); end
            n_checks++;
            if (q !== q_exp) begin n_fail++; $display("FAIL rand_q cyc %0d got %h want %h", c, q, q_exp); end
            n_checks++;
            if (qbar !== ~q_exp) begin n_fail++; $display("FAIL rand_qbar cyc %0d got %h want %h", c, qbar, ~q_exp); end
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_bubble();
        test_flush();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_pipe.md
# reg_pipe

Parametrised multi-stage register pipeline: the next generation of the team's single-bit synchronous-reset D flip-flop. It carries a WIDTH-bit word through DEPTH register stages. Each stage has a valid/ready handshake, so the pipeline absorbs back-pressure and collapses bubbles. It also provides synchronous flush, an occupancy count, and an optional registered complement output. It is the standard retiming/buffering element placed between datapath blocks sharing one clock.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of register stages (≥1)
- RESET_VAL, {WIDTH{1'b0}}, data value loaded into every stage on reset
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset; sampled only on clk rising edge
- flush  input  1  synchronous clear of all stage valids
- in_valid  input  1  upstream word present on d
- in_ready  output  1  pipeline accepts d this cycle
- d  input  WIDTH  input word
- out_valid  output  1  q holds a valid word
- out_ready  input  1  downstream accepts q this cycle
- q  output  WIDTH  last-stage data
- qbar  output  WIDTH  bitwise complement of q; present only with REG_PIPE_QBAR_EN
- count  output  $clog2(DEPTH+1)  number of valid stages

## Operation
- Stage i holds data[i] and valid[i]. Stage 0 is the input stage. Stage DEPTH-1 drives q and out_valid.
- Readiness, combinational:
  - ready[DEPTH] = out_ready
  - ready[i] = !valid[i] || ready[i+1]
  - in_ready = ready[0] && !flush
- Stage i loads on a clock edge when ready[i] is 1:
  - data[i] takes the upstream value: d for stage 0, data[i-1] otherwise.
  - valid[i] takes the upstream valid: in_valid && !flush for stage 0, valid[i-1] otherwise.
- data[i] is written only when the incoming valid is 1. An empty stage keeps its stale data.
- A stalled stage (ready[i]=0) holds both data and valid.
- Bubble collapse: an empty stage accepts a word even while the output is stalled.
- Transfers:
  - Input transfer: in_valid && in_ready at an edge.
  - Output transfer: out_valid && out_ready at an edge.
- Priority at each edge: reset > flush > normal operation.
- reset:
  - All valid[i] clear to 0 and all data[i] load RESET_VAL.
  - count clears to 0 and qbar (when enabled) loads ~RESET_VAL.
  - A reset asserted mid-stream discards every in-flight word.
- flush:
  - All valid[i] clear to 0 and count clears to 0. data[i] keeps its value.
  - in_ready is 0 during the flush cycle, so no input transfer occurs.
  - An output transfer in the same cycle (out_valid && out_ready) still completes; that word counts as delivered.
- count is registered and equals the sum of valid[i] after each edge. Arithmetic is unsigned and never exceeds DEPTH.
- qbar is registered alongside data[DEPTH-1], always equal to ~q in the same cycle. It is never derived from the previous q.

## Timing
- Reset values:
  - in_ready = 1 (combinational, with flush=0); out_valid = 0; count = 0.
  - q = RESET_VAL; qbar = ~RESET_VAL.
- Latency: a word accepted at edge N appears on q with out_valid=1 after edge N+DEPTH-1, given no stall. Earliest consumption is at edge N+DEPTH.
- Throughput: one word per cycle with out_ready held at 1.
- Full (count=DEPTH) with out_ready=0: in_ready=0 and all stages hold.
- Full with out_ready=1: in_ready=1. Simultaneous input and output transfer leaves count at DEPTH.
- in_ready depends combinationally on out_ready through DEPTH levels. Every other output is registered.
- DEPTH=1: a single stage; in_ready = !out_valid || out_ready.

## Configuration
- REG_PIPE_QBAR_EN:
  - Defined: the qbar port and its WIDTH-bit register exist, with the behaviour specified above.
  - Undefined: qbar is absent from the port list and from the logic. All other behaviour is identical.

## Test plan
- Reset: hold reset=1 for 2 edges with in_valid=1, d=8'hA5. Required: out_valid=0, count=0, q=8'h00, qbar=8'hFF, in_ready=1.
- Streaming (WIDTH=8, DEPTH=4): feed words 1,2,3,… one per cycle from edge 0 with out_ready=1. Required: word 1 on q after edge 3, then one new word per cycle, count=4 in steady state.
- Back-pressure: fill 4 words with out_ready=0. Required: count=4, in_ready=0, q holds word 1. Raise out_ready for 1 cycle: exactly one output transfer, in_ready=1 that cycle, count remains 4 when a new input is accepted.
- Bubble collapse: send word 1, leave 2 idle cycles, then send word 2, all with out_ready=0. Required: count=2 and the two words sit in stages 3 and 2.
- Flush: hold 3 words with out_ready=1, then assert flush for 1 cycle with in_valid=1. Required: word on q delivered that cycle, flushed input dropped, count=0 and out_valid=0 after the edge, q unchanged.
- Mid-operation reset with REG_PIPE_QBAR_EN defined: assert reset while count=4. Required: count=0 and out_valid=0 on the next edge, q=RESET_VAL, qbar=~RESET_VAL, and qbar=~q on every cycle of the test.
